// File: rtl/rca_pkg.sv
// Shared types and default sizing for the pipelined ripple-carry adder/subtractor.
package rca_pkg;

  typedef enum logic {OP_ADD, OP_SUB} op_t;

  localparam int RCA_WIDTH = 16;
  localparam int RCA_CHUNK = 4;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rca_chunk.sv
// Combinational N-bit ripple-carry adder built from full_adder cells.
module rca_chunk #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         c_msb_in
);

  logic [N:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_bit
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .sum (sum[i]),
      .cout(c[i+1])
    );
  end

  assign cout     = c[N];
  assign c_msb_in = c[N-1];

endmodule

// File: rtl/rca_pipe.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit ripple stage per pipeline
// register, valid/ready on both sides, carry/overflow/zero flags on the result.
module rca_pipe
  import rca_pkg::*;
#(
  parameter int WIDTH = RCA_WIDTH,
  parameter int CHUNK = RCA_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  op_t              op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int STAGES = WIDTH / CHUNK;

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("rca_pipe: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  // b is stored already inverted for OP_SUB, so later stages never look at op.
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic             c_msb;
    op_t              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
  } stage_t;

  stage_t [STAGES-1:0] stage_q;
  stage_t [STAGES-1:0] stage_d;

  logic             en;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  // Global advance: the whole pipe moves together, bubbles included.
  assign en       = !out_valid_q || out_ready;
  assign in_ready = en && !rst;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t           src;
    stage_t           nxt;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic             chunk_c_msb;

    if (k == 0) begin : g_first
      always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        src       = '0;
        src.valid = in_valid && in_ready;
        src.carry = cin;
        src.op    = op;
        src.a     = a;
        src.b     = (op == OP_SUB) ? ~b : b;
      end
    end else begin : g_next
      assign src = stage_q[k-1];
    end

    rca_chunk #(.N(CHUNK)) u_chunk (
      .a       (src.a[k*CHUNK +: CHUNK]),
      .b       (src.b[k*CHUNK +: CHUNK]),
      .cin     (src.carry),
      .sum     (chunk_sum),
      .cout    (chunk_cout),
      .c_msb_in(chunk_c_msb)
    );

    always_comb begin
      nxt                       = src;
      nxt.sum[k*CHUNK +: CHUNK] = chunk_sum;
      nxt.carry                 = chunk_cout;
      nxt.c_msb                 = chunk_c_msb;
    end

    assign stage_d[k] = nxt;
  end

  always_comb begin
    out_valid_d = stage_q[STAGES-1].valid;
    sum_d       = stage_q[STAGES-1].sum;
    cout_d      = stage_q[STAGES-1].carry;
    ovf_d       = stage_q[STAGES-1].carry ^ stage_q[STAGES-1].c_msb;
    zero_d      = (stage_q[STAGES-1].sum == '0);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: only the valid bits need reset; stage data is don't-care while its valid bit is 0.
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k].valid <= 1'b0;
      end
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b1;
    end else if (en) begin
      stage_q     <= stage_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

  // Each stage only consumes some fields of its predecessor; the rest are dropped here.
  logic unused_stage_bits;
  assign unused_stage_bits = ^stage_q;

endmodule

// File: tb/tb_rca_pipe.sv
// Directed and reference-model bench for rca_pipe at 16/4, 8/8 and 32/8.
module tb_rca_pipe;
  import rca_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // WIDTH=16, CHUNK=4
  logic        iv16 = 1'b0, ir16, ov16, or16 = 1'b1;
  logic [15:0] a16 = '0, b16 = '0, sum16;
  logic        cin16 = 1'b0, cout16, ovf16, zero16;
  op_t         op16 = OP_ADD;

  // WIDTH=8, CHUNK=8
  logic        iv8 = 1'b0, ir8, ov8, or8 = 1'b1;
  logic [7:0]  a8 = '0, b8 = '0, sum8;
  logic        cin8 = 1'b0, cout8, ovf8, zero8;
  op_t         op8 = OP_ADD;

  // WIDTH=32, CHUNK=8
  logic        iv32 = 1'b0, ir32, ov32, or32 = 1'b1;
  logic [31:0] a32 = '0, b32 = '0, sum32;
  logic        cin32 = 1'b0, cout32, ovf32, zero32;
  op_t         op32 = OP_ADD;

  rca_pipe #(.WIDTH(16), .CHUNK(4)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(cin16), .op(op16), .out_valid(ov16), .out_ready(or16), .sum(sum16),
    .cout(cout16), .ovf(ovf16), .zero(zero16)
  );

  rca_pipe #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8), .op(op8), .out_valid(ov8), .out_ready(or8), .sum(sum8),
    .cout(cout8), .ovf(ovf8), .zero(zero8)
  );

  rca_pipe #(.WIDTH(32), .CHUNK(8)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .cin(cin32), .op(op32), .out_valid(ov32), .out_ready(or32), .sum(sum32),
    .cout(cout32), .ovf(ovf32), .zero(zero32)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, cout, zero, sum} packed as in the result comparisons.
  function automatic logic [34:0] model(input int w, input logic [31:0] ta, input logic [31:0] tb,
                                        input logic tcin, input op_t top);
    logic [31:0] mask;
    logic [31:0] bb;
    logic [32:0] full;
    logic [31:0] s;
    logic        co;
    logic        ov;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    bb   = ((top == OP_SUB) ? ~tb : tb) & mask;
    full = {1'b0, ta & mask} + {1'b0, bb} + {32'd0, tcin};
    s    = full[31:0] & mask;
    co   = full[w];
    ov   = (ta[w-1] == bb[w-1]) && (s[w-1] != ta[w-1]);
    return {ov, co, (s == 32'd0), s};
  endfunction

  task automatic single16(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                          input logic tcin, input op_t top, input logic [15:0] es,
                          input logic ec, input logic eo, input logic ez);
    int lat;
    a16 = ta; b16 = tb; cin16 = tcin; op16 = top; iv16 = 1'b1; or16 = 1'b1;
    #1;
    check({tag, "_rdy"}, ir16, 1'b1);
    @(posedge clk); #1;
    iv16 = 1'b0;
    lat  = 0;
    while (!ov16 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, 4);
    check({tag, "_res"}, {ovf16, cout16, zero16, sum16}, {eo, ec, ez, es});
    @(posedge clk); #1;
  endtask

  task automatic single8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                         input logic tcin, input op_t top, input logic [7:0] es,
                         input logic ec, input logic eo, input logic ez);
    int lat;
    a8 = ta; b8 = tb; cin8 = tcin; op8 = top; iv8 = 1'b1; or8 = 1'b1;
    #1;
    check({tag, "_rdy"}, ir8, 1'b1);
    @(posedge clk); #1;
    iv8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, 1);
    check({tag, "_res"}, {ovf8, cout8, zero8, sum8}, {eo, ec, ez, es});
    @(posedge clk); #1;
  endtask

  // Eight back-to-back beats with out_ready low in slots 6..8.
  task automatic backpressure16();
    logic [15:0] ra[8], rb[8];
    logic        rc[8];
    op_t         rop[8];
    logic [34:0] expq[$];
    logic        accept, pop;
    int          sent, got, t;
    for (int i = 0; i < 8; i++) begin
      ra[i]  = 16'($urandom);
      rb[i]  = 16'($urandom);
      rc[i]  = 1'($urandom_range(0, 1));
      rop[i] = op_t'($urandom_range(0, 1));
    end
    sent = 0; got = 0; t = 0;
    while (got < 8 && t < 60) begin
      or16 = !(t >= 6 && t <= 8);
      iv16 = (sent < 8);
      if (sent < 8) begin
        a16 = ra[sent]; b16 = rb[sent]; cin16 = rc[sent]; op16 = rop[sent];
      end
      #1;
      if (t <= 10) check($sformatf("bp_in_ready_t%0d", t), ir16, !(t >= 6 && t <= 8));
      accept = iv16 && ir16;
      pop    = ov16 && or16;
      if (ov16 && expq.size() > 0) begin
        check($sformatf("bp_res_t%0d", t), {ovf16, cout16, zero16, sum16},
              {expq[0][34:32], expq[0][15:0]});
      end else if (ov16) begin
        check($sformatf("bp_extra_t%0d", t), 1'b1, 1'b0);
      end
      if (accept) expq.push_back(model(16, {16'd0, a16}, {16'd0, b16}, cin16, op16));
      @(posedge clk); #1;
      if (pop && expq.size() > 0) begin
        void'(expq.pop_front());
        got++;
      end
      if (accept) sent++;
      t++;
    end
    iv16 = 1'b0;
    or16 = 1'b1;
    check("bp_count", got, 8);
  endtask

  task automatic reset_midflight16();
    or16 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a16 = 16'(16'h0100 * (i + 1)); b16 = 16'h0003; cin16 = 1'b0; op16 = OP_ADD; iv16 = 1'b1;
      @(posedge clk); #1;
    end
    iv16 = 1'b0;
    rst  = 1'b1;
    #1;
    check("rst_in_ready", ir16, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_flags", {ov16, ovf16, cout16, zero16, sum16}, {4'b0001, 16'h0000});
    a16 = 16'h0010; b16 = 16'h0020; cin16 = 1'b0; op16 = OP_ADD; iv16 = 1'b1;
    #1;
    check("rst_new_rdy", ir16, 1'b1);
    @(posedge clk); #1;
    iv16 = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk); #1;
      check($sformatf("rst_ov_%0d", i), ov16, (i == 4));
      if (ov16) check($sformatf("rst_sum_%0d", i), sum16, 16'h0030);
    end
  endtask

  task automatic stream32();
    logic [34:0] expq[$];
    logic        accept, pop;
    int          sent, got, t;
    sent = 0; got = 0; t = 0;
    while (got < 1000 && t < 20000) begin
      or32  = ($urandom_range(0, 3) != 0);
      iv32  = (sent < 1000) && ($urandom_range(0, 7) != 0);
      a32   = $urandom;
      b32   = $urandom;
      cin32 = 1'($urandom_range(0, 1));
      op32  = op_t'($urandom_range(0, 1));
      #1;
      accept = iv32 && ir32;
      pop    = ov32 && or32;
      if (pop) begin
        if (expq.size() > 0) check($sformatf("s32_res_%0d", got), {ovf32, cout32, zero32, sum32}, expq[0]);
        else                 check($sformatf("s32_extra_%0d", got), 1'b1, 1'b0);
      end
      if (accept) expq.push_back(model(32, a32, b32, cin32, op32));
      @(posedge clk); #1;
      if (pop && expq.size() > 0) begin
        void'(expq.pop_front());
        got++;
      end
      if (accept) sent++;
      t++;
    end
    iv32 = 1'b0;
    or32 = 1'b1;
    check("s32_count", got, 1000);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready16", ir16, 1'b0);
    check("reset_state16", {ov16, ovf16, cout16, zero16, sum16}, {4'b0001, 16'h0000});
    check("reset_state8", {ir8, ov8, zero8, sum8}, {3'b001, 8'h00});
    check("reset_in_ready32", ir32, 1'b0);
    rst = 1'b0;
    #1;
    check("post_reset_ready16", ir16, 1'b1);
    @(posedge clk); #1;

    single16("carry_wrap", 16'hFFFF, 16'h0001, 1'b0, OP_ADD, 16'h0000, 1'b1, 1'b0, 1'b1);
    single16("add_ovf",    16'h7FFF, 16'h0001, 1'b0, OP_ADD, 16'h8000, 1'b0, 1'b1, 1'b0);
    single16("sub_borrow", 16'h0005, 16'h0007, 1'b1, OP_SUB, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    single16("sub_ovf",    16'h8000, 16'h0001, 1'b1, OP_SUB, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    single16("sub_equal",  16'h1234, 16'h1234, 1'b1, OP_SUB, 16'h0000, 1'b1, 1'b0, 1'b1);
    single16("add_cin",    16'h00FF, 16'h0F00, 1'b1, OP_ADD, 16'h1000, 1'b0, 1'b0, 1'b0);

    single8("w8_wrap", 8'h80, 8'h80, 1'b0, OP_ADD, 8'h00, 1'b1, 1'b1, 1'b1);
    single8("w8_ovf",  8'h7F, 8'h01, 1'b0, OP_ADD, 8'h80, 1'b0, 1'b1, 1'b0);

    backpressure16();
    reset_midflight16();
    stream32();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
